// File: rtl/ahb_uart_rx.sv
// AHB-Lite slave UART receiver (8N1, LSB first) with a single-byte receive buffer,
// W1C error flags, a programmable baud divider and a level interrupt while a byte waits.
module ahb_uart_rx #(
  parameter int unsigned DIVIDER_RESET = 434
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  input  logic        UART_RX,
  output logic        RX_IRQ
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Bus adapter state
  logic [3:0]  reg_addr;
  logic        write_dly;
  logic        sel_dly;

  // Registers and status
  logic [31:0] dvdr_q;
  logic [7:0]  rx_buf;
  logic        rx_valid;
  logic        overrun;
  logic        frame_err;
  logic        busy;

  // Input path
  logic        sync1_q, sync_q, prev_q;
  logic        fall;

  // Receiver datapath
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] div_q, div_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        stop_sample;

  logic        rd_data;
  logic        ctrl_wr;
  logic        dvdr_wr;
  logic        unused_addr;

  assign unused_addr = ^{HADDR[31:6], HADDR[1:0]};

  assign HREADY = 1'b1;
  assign HRESP  = 1'b0;
  assign RX_IRQ = rx_valid;
  assign busy   = (state_q != StIdle);
  assign fall   = prev_q & ~sync_q;

  assign rd_data = sel_dly & ~write_dly & (reg_addr == 4'h0);
  assign ctrl_wr = sel_dly & write_dly & (reg_addr == 4'h1);
  assign dvdr_wr = sel_dly & write_dly & (reg_addr == 4'h2);

  // Address-phase capture; deliberately not reset so it tracks the bus every cycle
  always_ff @(posedge HCLK) begin
    reg_addr  <= HADDR[5:2];
    write_dly <= HWRITE;
    sel_dly   <= HSEL;
  end

  // Read mux driven from the registered address
  always_comb begin
    HRDATA = 32'h0;
    case (reg_addr)
      4'h0:    HRDATA = {24'h0, rx_buf};
      4'h1:    HRDATA = {16'h55AA, 12'h0, overrun, frame_err, busy, rx_valid};
      4'h2:    HRDATA = dvdr_q;
      default: HRDATA = 32'h0;
    endcase
  end

  // Divider register; 0 and 1 would break mid-bit sampling so they clamp to 2
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dvdr_q <= 32'(DIVIDER_RESET);
    end else if (dvdr_wr) begin
      dvdr_q <= (HWDATA < 32'd2) ? 32'd2 : HWDATA;
    end
  end

  // Two-flop synchroniser plus previous-value flop for edge detection; idle-high reset
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= UART_RX;
      sync_q  <= sync1_q;
      prev_q  <= sync_q;
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      cnt_q    <= 32'h0;
      div_q    <= 32'h0;
      bitcnt_q <= 3'h0;
      shift_q  <= 8'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
    end
  end

  // Receiver next-state: half-bit wait to mid start bit, then one full bit per sample
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          div_d   = dvdr_q;
          cnt_d   = (dvdr_q >> 1) - 32'd1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == 32'h0) begin
          if (!sync_q) begin
            cnt_d    = div_q - 32'd1;
            bitcnt_d = 3'h0;
            state_d  = StData;
          end else begin
            // Glitch: line back high at mid start bit
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StData: begin
        if (cnt_q == 32'h0) begin
          shift_d = {sync_q, shift_q[7:1]};
          cnt_d   = div_q - 32'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StStop: begin
        if (cnt_q == 32'h0) begin
          stop_sample = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Buffer and flags; later assignments give flag sets priority over W1C clears
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_buf    <= 8'h0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rd_data) begin
        rx_valid <= 1'b0;
      end
      if (ctrl_wr) begin
        if (HWDATA[3]) overrun <= 1'b0;
        if (HWDATA[2]) frame_err <= 1'b0;
      end
      if (stop_sample) begin
        if (!rx_valid || rd_data) begin
          rx_buf   <= shift_q;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
        if (!sync_q) begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_uart_rx.sv
// Self-checking bench for ahb_uart_rx: bus-driven register checks plus a serial-line
// driver whose sent bytes are queued as expectations and popped on DATA reads.
module tb_ahb_uart_rx;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        UART_RX;
  logic        RX_IRQ;

  int          n_checks;
  int          n_errors;
  int          bit_cycles;
  logic [7:0]  exp_q[$];
  logic [31:0] rd;

  localparam logic [31:0] AddrData = 32'h0;
  localparam logic [31:0] AddrCtrl = 32'h4;
  localparam logic [31:0] AddrDvdr = 32'h8;

  ahb_uart_rx #(.DIVIDER_RESET(434)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .HADDR   (HADDR),
    .HWDATA  (HWDATA),
    .HWRITE  (HWRITE),
    .HSEL    (HSEL),
    .HRDATA  (HRDATA),
    .HREADY  (HREADY),
    .HRESP   (HRESP),
    .UART_RX (UART_RX),
    .RX_IRQ  (RX_IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge HCLK); #1;
    HADDR = addr; HWRITE = 1'b1; HSEL = 1'b1;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HWRITE = 1'b0; HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge HCLK); #1;
    HADDR = addr; HWRITE = 1'b0; HSEL = 1'b1;
    @(posedge HCLK); #1;
    HSEL = 1'b0;
    data = HRDATA;
  endtask

  // Read DATA and compare against the oldest queued byte
  task automatic read_data_sb(input string tag);
    logic [31:0] d;
    logic [7:0]  e;
    bus_read(AddrData, d);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, d, {24'h0, e});
    end
  endtask

  // Serial frame {stop, data, start}; cut >= 0 abandons the frame after that many cycles
  task automatic drive_frame(input logic [7:0] b, input logic stop_lvl, input int cut);
    logic [9:0] fr;
    int n;
    fr = {stop_lvl, b, 1'b0};
    n = 0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < bit_cycles; c++) begin
        if (cut >= 0 && n == cut) begin
          UART_RX = 1'b1;
          return;
        end
        @(posedge HCLK); #1;
        UART_RX = fr[i];
        n++;
      end
    end
    @(posedge HCLK); #1;
    UART_RX = 1'b1;
  endtask

  task automatic wait_irq(input string tag);
    int k;
    for (k = 0; k < 6000; k++) begin
      if (RX_IRQ === 1'b1) break;
      @(posedge HCLK); #1;
    end
    if (k == 6000) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    #1;
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bit_cycles = 16;
    HADDR = 32'h0; HWDATA = 32'h0; HWRITE = 1'b0; HSEL = 1'b0; UART_RX = 1'b1;
    do_reset();

    // Reset state
    check("rst_irq", {31'h0, RX_IRQ}, 32'h0);
    bus_read(AddrCtrl, rd); check("rst_ctrl", rd, 32'h55AA0000);
    bus_read(AddrDvdr, rd); check("rst_dvdr", rd, 32'd434);
    bus_read(AddrData, rd); check("rst_data", rd, 32'h0);

    // Divider clamp
    bus_write(AddrDvdr, 32'd1); bus_read(AddrDvdr, rd); check("dvdr_clamp1", rd, 32'd2);
    bus_write(AddrDvdr, 32'd0); bus_read(AddrDvdr, rd); check("dvdr_clamp0", rd, 32'd2);
    bus_write(AddrDvdr, 32'd16); bus_read(AddrDvdr, rd); check("dvdr_16", rd, 32'd16);

    // Single clean byte
    exp_q.push_back(8'hA5);
    drive_frame(8'hA5, 1'b1, -1);
    wait_irq("a5");
    bus_read(AddrCtrl, rd); check("a5_ctrl_valid", rd, 32'h55AA0001);
    read_data_sb("a5_data");
    bus_read(AddrCtrl, rd); check("a5_ctrl_clr", rd, 32'h55AA0000);

    // Overrun: second byte is dropped
    exp_q.push_back(8'h11);
    drive_frame(8'h11, 1'b1, -1);
    drive_frame(8'h22, 1'b1, -1);
    wait_irq("ovr");
    repeat (8) @(posedge HCLK);
    #1;
    bus_read(AddrCtrl, rd); check("ovr_ctrl", rd, 32'h55AA0009);
    read_data_sb("ovr_data");
    bus_write(AddrCtrl, 32'h8);
    bus_read(AddrCtrl, rd); check("ovr_w1c", rd, 32'h55AA0000);

    // Framing error: byte still delivered
    exp_q.push_back(8'h3C);
    drive_frame(8'h3C, 1'b0, -1);
    wait_irq("fe");
    repeat (4) @(posedge HCLK);
    #1;
    read_data_sb("fe_data");
    bus_read(AddrCtrl, rd); check("fe_ctrl", rd, 32'h55AA0004);
    bus_write(AddrCtrl, 32'h4);
    bus_read(AddrCtrl, rd); check("fe_w1c", rd, 32'h55AA0000);

    // Short low glitch: busy briefly, nothing delivered
    @(posedge HCLK); #1;
    UART_RX = 1'b0;
    repeat (5) @(posedge HCLK);
    #1;
    UART_RX = 1'b1;
    bus_read(AddrCtrl, rd); check("glitch_busy", rd, 32'h55AA0002);
    repeat (20) @(posedge HCLK);
    #1;
    bus_read(AddrCtrl, rd); check("glitch_idle", rd, 32'h55AA0000);
    check("glitch_irq", {31'h0, RX_IRQ}, 32'h0);

    // Reset in the middle of data bit 4
    drive_frame(8'hFF, 1'b1, 16 * 5 + 8);
    do_reset();
    bus_read(AddrCtrl, rd); check("mrst_ctrl", rd, 32'h55AA0000);
    bus_read(AddrDvdr, rd); check("mrst_dvdr", rd, 32'd434);
    bus_read(AddrData, rd); check("mrst_data", rd, 32'h0);
    check("mrst_irq", {31'h0, RX_IRQ}, 32'h0);

    // Clean frame at the reset divider (stands in for a transmitter loopback)
    bit_cycles = 434;
    exp_q.push_back(8'hC3);
    drive_frame(8'hC3, 1'b1, -1);
    wait_irq("lb");
    check("lb_irq_high", {31'h0, RX_IRQ}, 32'h1);
    read_data_sb("lb_data");
    @(posedge HCLK); #1;
    check("lb_irq_low", {31'h0, RX_IRQ}, 32'h0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
